vfu_result_wb_buffer: RTL and testbench

// Per-lane writeback buffer directly downstream of the lane FU stage (ALU and MFPU result ports).

---
 rtl/vfu_result_wb_buffer.sv | 149 ++++++++++++++
 tb/tb_vfu_result_wb_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfu_result_wb_buffer.sv
// ============================================================================
// Module      : vfu_result_wb_buffer
// Description : Per-lane writeback buffer. Two FU result FIFOs (ALU, MFPU)
//               merged onto one VRF write port by a lock-stable round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vfu_result_wb_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10,
    parameter int ID_WIDTH   = 3,
    parameter int DEPTH      = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        alu_req_i,
    input  logic [ID_WIDTH-1:0]         alu_id_i,
    input  logic [ADDR_WIDTH-1:0]       alu_addr_i,
    input  logic [DATA_WIDTH-1:0]       alu_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]     alu_be_i,
    output logic                        alu_gnt_o,

    input  logic                        mfpu_req_i,
    input  logic [ID_WIDTH-1:0]         mfpu_id_i,
    input  logic [ADDR_WIDTH-1:0]       mfpu_addr_i,
    input  logic [DATA_WIDTH-1:0]       mfpu_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]     mfpu_be_i,
    output logic                        mfpu_gnt_o,

    output logic                        vrf_req_o,
    output logic [ID_WIDTH-1:0]         vrf_id_o,
    output logic [ADDR_WIDTH-1:0]       vrf_addr_o,
    output logic [DATA_WIDTH-1:0]       vrf_wdata_o,
    output logic [DATA_WIDTH/8-1:0]     vrf_be_o,
    output logic                        vrf_src_o,
    input  logic                        vrf_gnt_i,

    output logic [$clog2(DEPTH):0]      alu_occ_o,
    output logic [$clog2(DEPTH):0]      mfpu_occ_o,
    output logic                        idle_o
);

    localparam int c_BE_W    = DATA_WIDTH / 8;
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_OCC_W   = $clog2(DEPTH) + 1;
    localparam int c_ENTRY_W = ID_WIDTH + ADDR_WIDTH + DATA_WIDTH + c_BE_W;

    logic [1:0]           w_req;
    logic [1:0]           w_gnt;
    logic [1:0]           w_pop;
    logic [1:0]           w_nonempty;
    logic [c_ENTRY_W-1:0] w_push_data [2];
    logic [c_ENTRY_W-1:0] w_head      [2];
    logic [c_OCC_W-1:0]   w_occ       [2];

    assign w_req          = {mfpu_req_i, alu_req_i};
    assign w_push_data[0] = {alu_id_i, alu_addr_i, alu_wdata_i, alu_be_i};
    assign w_push_data[1] = {mfpu_id_i, mfpu_addr_i, mfpu_wdata_i, mfpu_be_i};

    // Index 0 = ALU channel, index 1 = MFPU channel.
    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [c_ENTRY_W-1:0] r_mem [DEPTH];
        logic [c_PTR_W-1:0]   r_wptr;
        logic [c_PTR_W-1:0]   r_rptr;
        logic [c_OCC_W-1:0]   r_occ;

        // Grant looks only at occupancy, so a full FIFO never passes through.
        assign w_gnt[g] = w_req[g] & (r_occ < c_OCC_W'(DEPTH));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_occ  <= '0;
            end else begin
                if (w_gnt[g]) r_wptr <= r_wptr + 1'b1;
                if (w_pop[g]) r_rptr <= r_rptr + 1'b1;
                case ({w_gnt[g], w_pop[g]})
                    2'b10:   r_occ <= r_occ + 1'b1;
                    2'b01:   r_occ <= r_occ - 1'b1;
                    default: r_occ <= r_occ;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_gnt[g]) r_mem[r_wptr] <= w_push_data[g];
        end

        assign w_head[g]     = r_mem[r_rptr];
        assign w_occ[g]      = r_occ;
        assign w_nonempty[g] = (r_occ != '0);
    end

    logic                 r_lock;
    logic                 r_lock_sel;
    logic                 r_rr_last;
    logic                 w_sel;
    logic                 w_vrf_req;
    logic                 w_fire;
    logic [c_ENTRY_W-1:0] w_out;

    always_comb begin
        w_sel = 1'b0;
        if (r_lock) begin
            w_sel = r_lock_sel;
        end else if (w_nonempty == 2'b11) begin
            w_sel = ~r_rr_last;
        end else if (w_nonempty[1]) begin
            w_sel = 1'b1;
        end
    end

    assign w_vrf_req = w_nonempty[w_sel];
    assign w_fire    = w_vrf_req & vrf_gnt_i;
    assign w_pop     = {w_fire & w_sel, w_fire & ~w_sel};

    // r_rr_last resets to MFPU so the first tie goes to the ALU.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock     <= 1'b0;
            r_lock_sel <= 1'b0;
            r_rr_last  <= 1'b1;
        end else if (w_fire) begin
            r_lock    <= 1'b0;
            r_rr_last <= w_sel;
        end else if (w_vrf_req) begin
            r_lock     <= 1'b1;
            r_lock_sel <= w_sel;
        end
    end

    // Payload is zeroed while nothing is presented so stale RAM never shows.
    assign w_out = w_vrf_req ? w_head[w_sel] : '0;
    assign {vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o} = w_out;

    assign vrf_req_o  = w_vrf_req;
    assign vrf_src_o  = w_sel;
    assign alu_gnt_o  = w_gnt[0];
    assign mfpu_gnt_o = w_gnt[1];
    assign alu_occ_o  = w_occ[0];
    assign mfpu_occ_o = w_occ[1];
    assign idle_o     = (w_occ[0] == '0) & (w_occ[1] == '0);

endmodule

`default_nettype wire

// File: tb/tb_vfu_result_wb_buffer.sv
// ============================================================================
// Module      : tb_vfu_result_wb_buffer
// Description : Self-checking bench for vfu_result_wb_buffer against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vfu_result_wb_buffer;

    localparam int DW    = 128;
    localparam int AW    = 10;
    localparam int IW    = 3;
    localparam int DEPTH = 2;
    localparam int BW    = DW / 8;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } entry_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          alu_req_i = 1'b0, mfpu_req_i = 1'b0;
    logic [IW-1:0] alu_id_i = '0, mfpu_id_i = '0;
    logic [AW-1:0] alu_addr_i = '0, mfpu_addr_i = '0;
    logic [DW-1:0] alu_wdata_i = '0, mfpu_wdata_i = '0;
    logic [BW-1:0] alu_be_i = '0, mfpu_be_i = '0;
    logic          alu_gnt_o, mfpu_gnt_o;
    logic          vrf_req_o, vrf_src_o;
    logic          vrf_gnt_i = 1'b0;
    logic [IW-1:0] vrf_id_o;
    logic [AW-1:0] vrf_addr_o;
    logic [DW-1:0] vrf_wdata_o;
    logic [BW-1:0] vrf_be_o;
    logic [$clog2(DEPTH):0] alu_occ_o, mfpu_occ_o;
    logic          idle_o;

    vfu_result_wb_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alu_req_i(alu_req_i), .alu_id_i(alu_id_i), .alu_addr_i(alu_addr_i),
        .alu_wdata_i(alu_wdata_i), .alu_be_i(alu_be_i), .alu_gnt_o(alu_gnt_o),
        .mfpu_req_i(mfpu_req_i), .mfpu_id_i(mfpu_id_i), .mfpu_addr_i(mfpu_addr_i),
        .mfpu_wdata_i(mfpu_wdata_i), .mfpu_be_i(mfpu_be_i), .mfpu_gnt_o(mfpu_gnt_o),
        .vrf_req_o(vrf_req_o), .vrf_id_o(vrf_id_o), .vrf_addr_o(vrf_addr_o),
        .vrf_wdata_o(vrf_wdata_o), .vrf_be_o(vrf_be_o), .vrf_src_o(vrf_src_o),
        .vrf_gnt_i(vrf_gnt_i),
        .alu_occ_o(alu_occ_o), .mfpu_occ_o(mfpu_occ_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    int     n_chk  = 0;
    int     n_fail = 0;

    // Reference model: one queue per FU, plus the arbiter's memory of the
    // last served channel and of an offer still waiting for the VRF.
    entry_t qa[$];
    entry_t qm[$];
    int     last_served = 1;
    bit     held = 0;
    int     held_src = 0;

    bit     fu_req [2];
    entry_t fu_pl  [2];
    int     gen_prob [2];
    bit     obs_fire;
    logic [AW-1:0] obs_addr;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t rand_entry();
        entry_t e;
        e.id   = IW'($urandom);
        e.addr = AW'($urandom);
        e.data = {$urandom, $urandom, $urandom, $urandom};
        e.be   = BW'($urandom);
        return e;
    endfunction

    function automatic int qsize(int ch);
        return (ch == 0) ? qa.size() : qm.size();
    endfunction

    function automatic entry_t qhead(int ch);
        return (ch == 0) ? qa[0] : qm[0];
    endfunction

    function automatic int exp_sel();
        if (held)                         return held_src;
        if (qa.size() > 0 && qm.size() > 0) return 1 - last_served;
        if (qm.size() > 0)                return 1;
        return 0;
    endfunction

    task automatic model_reset();
        qa.delete();
        qm.delete();
        last_served = 1;
        held        = 0;
        fu_req[0]   = 0;
        fu_req[1]   = 0;
    endtask

    task automatic drive_inputs();
        alu_req_i    = fu_req[0];
        alu_id_i     = fu_pl[0].id;
        alu_addr_i   = fu_pl[0].addr;
        alu_wdata_i  = fu_pl[0].data;
        alu_be_i     = fu_pl[0].be;
        mfpu_req_i   = fu_req[1];
        mfpu_id_i    = fu_pl[1].id;
        mfpu_addr_i  = fu_pl[1].addr;
        mfpu_wdata_i = fu_pl[1].data;
        mfpu_be_i    = fu_pl[1].be;
    endtask

    // One clock: drive, settle, compare against the model, clock, update model.
    task automatic cycle();
        int     s;
        bit     er;
        bit     eg0, eg1;
        entry_t h;
        for (int ch = 0; ch < 2; ch++)
            if (!fu_req[ch] && $urandom_range(99) < gen_prob[ch]) begin
                fu_req[ch] = 1;
                fu_pl[ch]  = rand_entry();
            end
        drive_inputs();
        #1;
        s   = exp_sel();
        er  = (qsize(s) > 0);
        eg0 = fu_req[0] && (qa.size() < DEPTH);
        eg1 = fu_req[1] && (qm.size() < DEPTH);
        chk("alu_gnt", alu_gnt_o, eg0);
        chk("mfpu_gnt", mfpu_gnt_o, eg1);
        chk("vrf_req", vrf_req_o, er);
        if (er) begin
            h = qhead(s);
            chk("vrf_src", vrf_src_o, s[0]);
            chk("vrf_id", vrf_id_o, h.id);
            chk("vrf_addr", vrf_addr_o, h.addr);
            chk("vrf_wdata", vrf_wdata_o, h.data);
            chk("vrf_be", vrf_be_o, h.be);
        end
        chk("alu_occ", alu_occ_o, qa.size());
        chk("mfpu_occ", mfpu_occ_o, qm.size());
        chk("idle", idle_o, (qa.size() == 0 && qm.size() == 0));
        obs_fire = vrf_req_o & vrf_gnt_i;
        obs_addr = vrf_addr_o;
        @(posedge clk_i);
        if (er && vrf_gnt_i) begin
            if (s == 0) void'(qa.pop_front()); else void'(qm.pop_front());
            last_served = s;
            held        = 0;
        end else if (er) begin
            held     = 1;
            held_src = s;
        end
        if (eg0) begin qa.push_back(fu_pl[0]); fu_req[0] = 0; end
        if (eg1) begin qm.push_back(fu_pl[1]); fu_req[1] = 0; end
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        gen_prob[0] = 0;
        gen_prob[1] = 0;
        vrf_gnt_i   = 1;
        while ((fu_req[0] || fu_req[1] || qa.size() != 0 || qm.size() != 0) && n < 50) begin
            cycle();
            n++;
        end
        chk({tag, "_drain_in_time"}, (n < 50), 1'b1);
        chk({tag, "_idle"}, idle_o, 1'b1);
    endtask

    initial begin
        int     next_addr;
        int     n;
        entry_t e;
        gen_prob[0] = 0;
        gen_prob[1] = 0;
        fu_pl[0]    = '0;
        fu_pl[1]    = '0;
        model_reset();

        // Reset state, checked while reset is asserted.
        #1 rst_ni = 0;
        #2;
        chk("rst_vrf_req", vrf_req_o, 1'b0);
        chk("rst_src", vrf_src_o, 1'b0);
        chk("rst_alu_occ", alu_occ_o, 0);
        chk("rst_mfpu_occ", mfpu_occ_o, 0);
        chk("rst_idle", idle_o, 1'b1);
        chk("rst_addr", vrf_addr_o, 0);
        chk("rst_alu_gnt", alu_gnt_o, 1'b0);
        @(posedge clk_i);
        #2 rst_ni = 1;
        @(posedge clk_i);
        #1;

        // T1: single ALU push, 1-cycle latency, idle after pop.
        vrf_gnt_i  = 1;
        fu_req[0]  = 1;
        fu_pl[0]   = rand_entry();
        fu_pl[0].id   = 3'd2;
        fu_pl[0].addr = 10'h010;
        fu_pl[0].be   = 16'hFFFF;
        cycle();
        cycle();
        chk("t1_fire", obs_fire, 1'b1);
        chk("t1_addr", obs_addr, 10'h010);
        cycle();
        chk("t1_idle", idle_o, 1'b1);

        // T2: both channels push every cycle, VRF always grants.
        gen_prob[0] = 100;
        gen_prob[1] = 100;
        vrf_gnt_i   = 1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            chk("t2_occ_bound", (alu_occ_o <= 2) && (mfpu_occ_o <= 2), 1'b1);
        end
        drain("t2");

        // T3: VRF stalls with both channels loaded; offer must stay put.
        gen_prob[0] = 100;
        gen_prob[1] = 100;
        vrf_gnt_i   = 0;
        for (int i = 0; i < 4; i++) cycle();
        for (int i = 0; i < 5; i++) cycle();
        chk("t3_alu_occ", alu_occ_o, 2);
        chk("t3_mfpu_occ", mfpu_occ_o, 2);
        chk("t3_alu_gnt", alu_gnt_o, 1'b0);
        drain("t3");

        // T4: full ALU FIFO, push and pop in the same cycle.
        gen_prob[0] = 100;
        gen_prob[1] = 0;
        vrf_gnt_i   = 0;
        cycle();
        cycle();
        vrf_gnt_i = 1;
        cycle();
        chk("t4_occ_after_pop", alu_occ_o, 1);
        vrf_gnt_i = 0;
        cycle();
        chk("t4_refill", alu_occ_o, 2);
        drain("t4");

        // T5: asynchronous reset with three entries buffered.
        gen_prob[0] = 0;
        gen_prob[1] = 0;
        vrf_gnt_i   = 0;
        fu_req[0] = 1; fu_pl[0] = rand_entry();
        cycle();
        fu_req[0] = 1; fu_pl[0] = rand_entry();
        fu_req[1] = 1; fu_pl[1] = rand_entry();
        cycle();
        chk("t5_loaded", alu_occ_o + mfpu_occ_o, 3);
        #2 rst_ni = 0;
        model_reset();
        drive_inputs();
        #1;
        chk("t5_vrf_req", vrf_req_o, 1'b0);
        chk("t5_occ", {alu_occ_o, mfpu_occ_o}, 0);
        chk("t5_idle", idle_o, 1'b1);
        chk("t5_src", vrf_src_o, 1'b0);
        chk("t5_payload", {vrf_id_o, vrf_addr_o, vrf_be_o}, 0);
        @(posedge clk_i);
        #2 rst_ni = 1;
        vrf_gnt_i = 1;
        cycle();
        cycle();

        // T6: ALU ordering under random VRF grants.
        next_addr = 0;
        n         = 0;
        begin
            int pushed = 0;
            while ((next_addr < 4) && n < 80) begin
                if (!fu_req[0] && pushed < 4) begin
                    e       = rand_entry();
                    e.addr  = AW'(pushed);
                    fu_pl[0] = e;
                    fu_req[0] = 1;
                    pushed++;
                end
                vrf_gnt_i = 1'($urandom_range(1));
                cycle();
                if (obs_fire) begin
                    chk("t6_order", obs_addr, AW'(next_addr));
                    next_addr++;
                end
                n++;
            end
        end
        chk("t6_all_seen", next_addr, 4);
        drain("t6");

        // Random traffic on both channels with random VRF back-pressure.
        for (int i = 0; i < 300; i++) begin
            gen_prob[0] = 60;
            gen_prob[1] = 60;
            vrf_gnt_i   = 1'($urandom_range(1));
            cycle();
        end
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
